// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian words from a byte stream
// and writes them to consecutive addresses until the halt word or the last address.
module imem_loader #(
  parameter int                   NB_DATA    = 32,
  parameter int                   NB_BYTE    = 8,
  parameter int                   NB_ADDRESS = 8,
  parameter int                   N_ADDRESS  = 256,
  parameter logic [NB_DATA-1:0]   HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic [NB_DATA-1:0]    o_mem_w_data,
  output logic [NB_ADDRESS-1:0] o_mem_w_addr,
  output logic                  o_mem_w_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [NB_ADDRESS:0]   o_word_count
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(N_BYTES - 1);
  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_ADDRESS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [NB_DATA-1:0]      assembly;
  logic [NB_DATA-1:0]      assembly_with_byte;
  logic [IDX_W-1:0]        byte_idx;
  logic [NB_ADDRESS-1:0]   addr;
  logic [NB_ADDRESS:0]     word_count;
  logic [NB_DATA-1:0]      w_data;
  logic [NB_ADDRESS-1:0]   w_addr;
  logic                    load_start;
  logic                    byte_accept;
  logic                    word_complete;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The write cycle decides the next state from the word it is presenting
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          state_next = RECV;
        end
      end
      RECV: begin
        if (i_rx_valid && (byte_idx == LAST_IDX)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (w_data == HALT_WORD) begin
          state_next = DONE;
        end else if (addr == LAST_ADDR) begin
          state_next = ERROR;
        end else begin
          state_next = RECV;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_start    = i_start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    byte_accept   = i_rx_valid &&
                    ((state == RECV) || ((state == WRITE) && (state_next == RECV)));
    word_complete = i_rx_valid && (state == RECV) && (byte_idx == LAST_IDX);
  end

  always_comb begin
    assembly_with_byte = assembly;
    assembly_with_byte[byte_idx*NB_BYTE +: NB_BYTE] = i_rx_data;
  end

  // A byte arriving during WRITE lands at index 0 (byte_idx was cleared on entry)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      assembly   <= '0;
      byte_idx   <= '0;
      addr       <= '0;
      word_count <= '0;
      w_data     <= '0;
      w_addr     <= '0;
    end else if (load_start) begin
      assembly   <= '0;
      byte_idx   <= '0;
      addr       <= '0;
      word_count <= '0;
    end else begin
      if (byte_accept) begin
        if (word_complete) begin
          w_data   <= assembly_with_byte;
          w_addr   <= addr;
          assembly <= '0;
          byte_idx <= '0;
        end else begin
          assembly <= assembly_with_byte;
          byte_idx <= byte_idx + 1'b1;
        end
      end
      if (state == WRITE) begin
        word_count <= word_count + 1'b1;
        addr       <= addr + 1'b1;
      end
    end
  end

  assign o_mem_w_data = w_data;
  assign o_mem_w_addr = w_addr;
  assign o_mem_w_en   = (state == WRITE);
  assign o_busy       = (state == RECV) || (state == WRITE);
  assign o_done       = (state == DONE);
  assign o_overflow   = (state == ERROR);
  assign o_word_count = word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a default-size and a 4-word instance share one stimulus
// stream and are each checked every cycle against a byte-queue model.
module tb_imem_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;

  logic [31:0] b_data;
  logic [7:0]  b_addr;
  logic        b_en, b_busy, b_done, b_ovf;
  logic [8:0]  b_count;

  logic [31:0] s_data;
  logic [1:0]  s_addr;
  logic        s_en, s_busy, s_done, s_ovf;
  logic [2:0]  s_count;

  imem_loader dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_mem_w_data (b_data),
    .o_mem_w_addr (b_addr),
    .o_mem_w_en   (b_en),
    .o_busy       (b_busy),
    .o_done       (b_done),
    .o_overflow   (b_ovf),
    .o_word_count (b_count)
  );

  imem_loader #(.NB_ADDRESS(2), .N_ADDRESS(4)) dut_small (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_mem_w_data (s_data),
    .o_mem_w_addr (s_addr),
    .o_mem_w_en   (s_en),
    .o_busy       (s_busy),
    .o_done       (s_done),
    .o_overflow   (s_ovf),
    .o_word_count (s_count)
  );

  // Loader behaviour in terms of "collecting bytes" and "a word waiting to be written"
  typedef struct packed {
    bit        loading;
    bit        pending;
    bit        done;
    bit        overflow;
    int        nbytes;
    int        next_addr;
    int        count;
    bit [31:0] acc;
    bit [31:0] wdata;
    int        waddr;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    return r;
  endfunction

  function automatic model_t model_step(model_t m, bit start, bit valid,
                                        logic [7:0] d, int n_addr);
    model_t r;
    r = m;
    if (m.pending) begin
      r.pending   = 1'b0;
      r.count     = m.count + 1;
      r.next_addr = m.next_addr + 1;
      if (m.wdata == HALT) begin
        r.done    = 1'b1;
        r.loading = 1'b0;
      end else if (m.waddr == n_addr - 1) begin
        r.overflow = 1'b1;
        r.loading  = 1'b0;
      end else if (valid) begin
        r.acc    = {24'b0, d};
        r.nbytes = 1;
      end
    end else if (m.loading) begin
      if (valid) begin
        r.acc    = m.acc | ({24'b0, d} << (8 * m.nbytes));
        r.nbytes = m.nbytes + 1;
        if (r.nbytes == 4) begin
          r.pending = 1'b1;
          r.wdata   = r.acc;
          r.waddr   = m.next_addr;
          r.nbytes  = 0;
          r.acc     = '0;
        end
      end
    end else if (start) begin
      r.loading   = 1'b1;
      r.done      = 1'b0;
      r.overflow  = 1'b0;
      r.count     = 0;
      r.next_addr = 0;
      r.nbytes    = 0;
      r.acc       = '0;
    end
    return r;
  endfunction

  model_t mb;
  model_t ms;

  int n_vectors;
  int n_miscompares;
  int cycle;

  logic [31:0] log_data[$];
  int          log_addr[$];
  int          log_cycle[$];
  int          s_log_addr[$];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mb <= model_reset();
      ms <= model_reset();
    end else begin
      mb <= model_step(mb, i_start, i_rx_valid, i_rx_data, 256);
      ms <= model_step(ms, i_start, i_rx_valid, i_rx_data, 4);
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cycle);
    end
  endtask

  // Per-cycle comparison of both instances against their models, plus write logging
  always @(posedge i_clk) begin
    #3;
    cycle++;
    check_output("big_en",      64'(b_en),    64'(mb.pending));
    check_output("big_data",    64'(b_data),  64'(mb.wdata));
    check_output("big_addr",    64'(b_addr),  64'(mb.waddr));
    check_output("big_busy",    64'(b_busy),  64'(mb.loading));
    check_output("big_done",    64'(b_done),  64'(mb.done));
    check_output("big_ovf",     64'(b_ovf),   64'(mb.overflow));
    check_output("big_count",   64'(b_count), 64'(mb.count));
    check_output("small_en",    64'(s_en),    64'(ms.pending));
    check_output("small_data",  64'(s_data),  64'(ms.wdata));
    check_output("small_addr",  64'(s_addr),  64'(ms.waddr));
    check_output("small_busy",  64'(s_busy),  64'(ms.loading));
    check_output("small_done",  64'(s_done),  64'(ms.done));
    check_output("small_ovf",   64'(s_ovf),   64'(ms.overflow));
    check_output("small_count", 64'(s_count), 64'(ms.count));
    if (b_en === 1'b1) begin
      log_data.push_back(b_data);
      log_addr.push_back(int'(b_addr));
      log_cycle.push_back(cycle);
    end
    if (s_en === 1'b1) begin
      s_log_addr.push_back(int'(s_addr));
    end
  end

  task automatic apply_stimulus(input bit rst, input bit start, input bit valid,
                                input logic [7:0] d);
    @(negedge i_clk);
    i_rst      = rst;
    i_start    = start;
    i_rx_valid = valid;
    i_rx_data  = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(0, 0, 0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 0, 1, t[7:0]);
      t = t >> 8;
      idle(gap);
    end
  endtask

  task automatic settle(input int n);
    idle(n);
    @(posedge i_clk);
    #3;
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_addr.delete();
    log_cycle.delete();
    s_log_addr.delete();
  endtask

  task automatic do_reset();
    apply_stimulus(1, 0, 0, 8'h00);
    @(posedge i_clk);
    #3;
    check_output("rst_data",  64'(b_data),  64'h0);
    check_output("rst_en",    64'(b_en),    64'h0);
    check_output("rst_busy",  64'(b_busy),  64'h0);
    check_output("rst_count", 64'(b_count), 64'h0);
    clear_logs();
    idle(1);
  endtask

  bit          r_start, r_valid, r_halt;
  logic [7:0]  r_data;
  int          r_phase;
  int          r_sel;

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    cycle         = 0;
    i_rst         = 1'b1;
    i_start       = 1'b0;
    i_rx_valid    = 1'b0;
    i_rx_data     = 8'h00;
    repeat (2) @(posedge i_clk);
    idle(2);

    // Basic three-word load ending with the halt word
    clear_logs();
    apply_stimulus(0, 1, 0, 8'h00);
    idle(1);
    send_word(32'h1234_5678, 1);
    send_word(32'h0000_0001, 1);
    send_word(HALT, 1);
    settle(3);
    check_output("t1_nwrites", 64'(log_data.size()), 64'd3);
    if (log_data.size() == 3) begin
      check_output("t1_w0", 64'(log_data[0]), 64'h1234_5678);
      check_output("t1_w1", 64'(log_data[1]), 64'h0000_0001);
      check_output("t1_w2", 64'(log_data[2]), 64'hFFFF_FFFF);
      check_output("t1_a2", 64'(log_addr[2]), 64'd2);
    end
    check_output("t1_done",  64'(b_done),  64'd1);
    check_output("t1_busy",  64'(b_busy),  64'd0);
    check_output("t1_count", 64'(b_count), 64'd3);
    check_output("t1_model_count", 64'(mb.count), 64'd3);
    check_output("t1_model_done",  64'(mb.done),  64'd1);

    // Address-space exhaustion on the 4-word instance
    clear_logs();
    apply_stimulus(0, 1, 0, 8'h00);
    for (int w = 0; w < 4; w++) send_word(32'h0000_0010 + 32'(w), 0);
    send_word(32'h5566_7788, 0);
    settle(3);
    check_output("t2_small_nwrites", 64'(s_log_addr.size()), 64'd4);
    if (s_log_addr.size() == 4) begin
      check_output("t2_small_a3", 64'(s_log_addr[3]), 64'd3);
    end
    check_output("t2_small_ovf",   64'(s_ovf),   64'd1);
    check_output("t2_small_count", 64'(s_count), 64'd4);
    check_output("t2_model_ovf",   64'(ms.overflow), 64'd1);

    // Bytes before start must not leak into the first word
    do_reset();
    apply_stimulus(0, 0, 1, 8'hAA);
    apply_stimulus(0, 0, 1, 8'hBB);
    apply_stimulus(0, 1, 0, 8'h00);
    send_word(32'h1122_3344, 0);
    send_word(HALT, 0);
    settle(3);
    check_output("t3_nwrites", 64'(log_data.size()), 64'd2);
    if (log_data.size() > 0) begin
      check_output("t3_w0", 64'(log_data[0]), 64'h1122_3344);
      check_output("t3_a0", 64'(log_addr[0]), 64'd0);
    end

    // Reset in the middle of a word discards it
    apply_stimulus(0, 1, 0, 8'h00);
    apply_stimulus(0, 0, 1, 8'h01);
    apply_stimulus(0, 0, 1, 8'h02);
    do_reset();
    apply_stimulus(0, 1, 0, 8'h00);
    send_word(32'h0807_0605, 0);
    send_word(HALT, 0);
    settle(3);
    check_output("t4_nwrites", 64'(log_data.size()), 64'd2);
    if (log_data.size() > 0) begin
      check_output("t4_w0", 64'(log_data[0]), 64'h0807_0605);
    end

    // Back-to-back bytes: writes exactly four cycles apart
    clear_logs();
    apply_stimulus(0, 1, 0, 8'h00);
    send_word(32'hA1B2_C3D4, 0);
    send_word(32'h0000_BEEF, 0);
    send_word(HALT, 0);
    settle(3);
    check_output("t5_nwrites", 64'(log_data.size()), 64'd3);
    if (log_data.size() == 3) begin
      check_output("t5_w0",   64'(log_data[0]), 64'hA1B2_C3D4);
      check_output("t5_w1",   64'(log_data[1]), 64'h0000_BEEF);
      check_output("t5_gap1", 64'(log_cycle[1] - log_cycle[0]), 64'd4);
      check_output("t5_gap2", 64'(log_cycle[2] - log_cycle[1]), 64'd4);
    end

    // Restart from DONE
    clear_logs();
    apply_stimulus(0, 1, 0, 8'h00);
    @(posedge i_clk);
    #3;
    check_output("t6_done",  64'(b_done),  64'd0);
    check_output("t6_busy",  64'(b_busy),  64'd1);
    check_output("t6_count", 64'(b_count), 64'd0);
    send_word(32'h00C0_FFEE, 0);
    send_word(HALT, 2);
    settle(3);
    check_output("t6_nwrites", 64'(log_data.size()), 64'd2);
    if (log_data.size() > 0) begin
      check_output("t6_a0", 64'(log_addr[0]), 64'd0);
      check_output("t6_w0", 64'(log_data[0]), 64'h00C0_FFEE);
    end
    check_output("t6_count_end", 64'(b_count), 64'd2);

    // Randomized traffic with occasional starts, resets and halt words
    r_phase = 0;
    r_halt  = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      r_sel = int'($urandom_range(0, 999));
      if (r_sel < 2) begin
        apply_stimulus(1, 0, 0, 8'h00);
        r_phase = 0;
      end else begin
        r_start = ($urandom_range(0, 99) < 3);
        r_valid = ($urandom_range(0, 99) < 75);
        r_data  = 8'($urandom);
        if (r_valid) begin
          if (r_phase == 0) r_halt = ($urandom_range(0, 11) == 0);
          if (r_halt) r_data = 8'hFF;
          r_phase = (r_phase + 1) % 4;
        end
        apply_stimulus(0, r_start, r_valid, r_data);
      end
    end
    settle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequencer that fills the instruction memory from the debug-unit byte stream. It accepts bytes over a valid-only interface (UART RX), assembles them little-endian into NB_DATA-bit words, and drives the memory write port (data, address, enable) at consecutive addresses starting at 0. Loading stops when the halt word has been written, or when the address space is exhausted (overflow). It sits between the UART receiver / debug unit and the write port of the instruction memory.

## Interface
- NB_DATA, 32, memory word width; must be a multiple of NB_BYTE
- NB_BYTE, 8, width of incoming byte
- NB_ADDRESS, 8, memory address width
- N_ADDRESS, 256, number of memory words (≤ 2^NB_ADDRESS)
- HALT_WORD, 32'hFFFF_FFFF, terminating instruction, width NB_DATA
- i_clk  input  1  single clock, all state updates on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_start  input  1  one-cycle request to begin a load at address 0
- i_rx_data  input  NB_BYTE  incoming byte
- i_rx_valid  input  1  i_rx_data valid this cycle; no backpressure
- o_mem_w_data  output  NB_DATA  assembled word to memory
- o_mem_w_addr  output  NB_ADDRESS  write address to memory
- o_mem_w_en  output  1  memory write enable, one-cycle pulse per word
- o_busy  output  1  high in RECV and WRITE
- o_done  output  1  high in DONE
- o_overflow  output  1  high in ERROR
- o_word_count  output  NB_ADDRESS+1  words written in current/last load

## Operation
- FSM states: IDLE, RECV, WRITE, DONE, ERROR. Reset state IDLE.
- IDLE: bytes ignored. i_start -> RECV; clear address, byte index, word count, assembly register.
- RECV: each i_rx_valid byte goes to bits [8k+7:8k] of the assembly register, k = byte index (first byte = LSB). When the byte at index NB_DATA/NB_BYTE-1 is accepted -> WRITE, byte index to 0.
- WRITE (exactly one cycle): o_mem_w_en=1, o_mem_w_data = assembled word, o_mem_w_addr = current address; word count +1; address +1.
  - word == HALT_WORD -> DONE (the halt word itself is written).
  - else address == N_ADDRESS-1 -> ERROR (no wrap; address is never reused).
  - else -> RECV.
- A byte valid during WRITE: captured as byte 0 of the next word when the next state is RECV; discarded when the next state is DONE or ERROR. No byte is lost at the maximum rate of one byte per cycle.
- DONE / ERROR: status held, bytes ignored, memory outputs static with o_mem_w_en=0. i_start -> RECV with full clear (new load from address 0).
- i_start in RECV or WRITE is ignored. i_start and i_rx_valid in the same cycle in IDLE/DONE/ERROR: the byte is ignored.
- Reset mid-load: partial word discarded, nothing written, all outputs to reset values.

## Timing
- Reset values: o_mem_w_data=0, o_mem_w_addr=0, o_mem_w_en=0, o_busy=0, o_done=0, o_overflow=0, o_word_count=0.
- All outputs registered. Status outputs decode the state register.
- Final byte of a word sampled at edge N -> o_mem_w_en high from edge N to edge N+1 with valid data/address; the memory captures at edge N+1.
- i_start sampled at edge N -> o_busy high after edge N. The first byte is accepted at edge N+1 or later.
- DONE/ERROR entered at the edge ending the WRITE cycle. o_word_count is updated at the same edge.
- Minimum load time for W words: W·(NB_DATA/NB_BYTE) byte cycles; WRITE overlaps the next byte.

## Test plan
- Defaults, start, then bytes 78 56 34 12, 01 00 00 00, FF FF FF FF -> writes addr0=0x12345678, addr1=0x00000001, addr2=0xFFFFFFFF; o_done=1, o_word_count=3, o_busy=0.
- NB_ADDRESS=2, N_ADDRESS=4, start, 4 non-halt words, then 4 more bytes -> exactly 4 writes (addr 0..3); o_overflow=1, o_word_count=4; no fifth o_mem_w_en.
- Bytes AA BB before i_start, then start and 44 33 22 11, FF×4 -> addr0=0x11223344, with no trace of AA/BB in the memory writes.
- Start, bytes 01 02, assert i_rst for 1 cycle, start, 05 06 07 08 -> all outputs 0 during reset; the only write before halt is addr0=0x08070605.
- i_rx_valid high every cycle with 12 bytes (two data words + halt) -> 3 writes, each exactly 4 cycles apart, correct values, no dropped byte.
- From DONE, i_start and a new 2-word stream -> o_done drops, o_word_count restarts at 0, writes begin at addr 0.
